// File: rtl/serial_src_pkg.sv
// Shared encodings and constants for the serial bit source.
package serial_src_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10
  } state_e;

  localparam int unsigned GapCntW = 4;

endpackage

// File: rtl/serial_bit_src.sv
// Parallel-to-serial word source: loads a word, shifts it out one bit per enabled cycle,
// then idles for a fixed number of gap cycles before accepting the next word.
module serial_bit_src
  import serial_src_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             en,
  output logic             x_out,
  output logic             x_valid,
  output logic             done,
  output logic [1:0]       state
);

  localparam int unsigned         CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]     CntLast = CntW'(WIDTH - 1);
  localparam logic [GapCntW-1:0]  GapLast = GapCntW'((GAP > 0) ? GAP - 1 : 0);
  localparam bit                  NoGap   = (GAP == 0);

  state_e               state_q;
  logic [WIDTH-1:0]     sreg_q;
  logic [CntW-1:0]      cnt_q;
  logic [GapCntW-1:0]   gcnt_q;
  logic                 accept;

  always_comb begin
    done     = (state_q == S_SHIFT) && (cnt_q == CntLast) && en;
    // With no gap, the final enabled bit can hand straight over to the next word.
    in_ready = !rst && ((state_q == S_IDLE) || (done && NoGap));
    accept   = in_valid && in_ready;
    x_valid  = (state_q == S_SHIFT);
    if (x_valid) begin
      x_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    end else begin
      x_out = IDLE_BIT;
    end
    state = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            sreg_q  <= in_data;
            cnt_q   <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (en) begin
            if (cnt_q == CntLast) begin
              if (!NoGap) begin
                state_q <= S_GAP;
                gcnt_q  <= '0;
              end else if (accept) begin
                sreg_q  <= in_data;
                cnt_q   <= '0;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              sreg_q <= MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
              cnt_q  <= cnt_q + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gcnt_q == GapLast) begin
            state_q <= S_IDLE;
          end else begin
            gcnt_q <= gcnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_src.sv
// Bench for serial_bit_src: three configurations checked every cycle against a word-level
// model, plus directed sequences with literal expected bit streams.
module tb_serial_bit_src;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s [3];
  logic       iv    [3];
  logic       en_s  [3];
  logic [7:0] id    [3];
  logic       rdy   [3];
  logic       xo    [3];
  logic       xv    [3];
  logic       dn    [3];
  logic [1:0] st    [3];

  serial_bit_src #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(1), .IDLE_BIT(1'b0)) dut_msb (
    .clk(clk), .rst(rst_s[0]), .in_valid(iv[0]), .in_data(id[0]), .in_ready(rdy[0]),
    .en(en_s[0]), .x_out(xo[0]), .x_valid(xv[0]), .done(dn[0]), .state(st[0])
  );

  serial_bit_src #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(1), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .rst(rst_s[1]), .in_valid(iv[1]), .in_data(id[1]), .in_ready(rdy[1]),
    .en(en_s[1]), .x_out(xo[1]), .x_valid(xv[1]), .done(dn[1]), .state(st[1])
  );

  serial_bit_src #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0), .IDLE_BIT(1'b0)) dut_gap0 (
    .clk(clk), .rst(rst_s[2]), .in_valid(iv[2]), .in_data(id[2]), .in_ready(rdy[2]),
    .en(en_s[2]), .x_out(xo[2]), .x_valid(xv[2]), .done(dn[2]), .state(st[2])
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit cfg_msb(input int k);
    return k != 1;
  endfunction

  function automatic int cfg_gap(input int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic bit cfg_idle(input int k);
    return k == 1;
  endfunction

  // Word-level model: which word is in flight, how many of its bits were already sent,
  // and how many gap cycles remain.
  bit         m_busy [3];
  logic [7:0] m_word [3];
  int         m_idx  [3];
  int         m_gap  [3];
  bit         armed = 1'b0;

  function automatic bit m_bit(input int k);
    return cfg_msb(k) ? m_word[k][7 - m_idx[k]] : m_word[k][m_idx[k]];
  endfunction

  function automatic bit m_done(input int k);
    return m_busy[k] && (m_idx[k] == 7) && en_s[k];
  endfunction

  function automatic bit m_ready(input int k);
    return !rst_s[k] && ((!m_busy[k] && m_gap[k] == 0) || (m_done(k) && cfg_gap(k) == 0));
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_s[k]) begin
        m_busy[k] <= 1'b0;
        m_idx[k]  <= 0;
        m_gap[k]  <= 0;
        armed     <= 1'b1;
      end else if (m_busy[k]) begin
        if (en_s[k]) begin
          if (m_idx[k] == 7) begin
            m_busy[k] <= 1'b0;
            m_gap[k]  <= cfg_gap(k);
            if (iv[k] && m_ready(k)) begin
              m_busy[k] <= 1'b1;
              m_word[k] <= id[k];
              m_idx[k]  <= 0;
            end
          end else begin
            m_idx[k] <= m_idx[k] + 1;
          end
        end
      end else if (m_gap[k] > 0) begin
        m_gap[k] <= m_gap[k] - 1;
      end else if (iv[k] && m_ready(k)) begin
        m_busy[k] <= 1'b1;
        m_word[k] <= id[k];
        m_idx[k]  <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model%0d.in_ready", k), rdy[k], m_ready(k));
        chk($sformatf("model%0d.x_valid", k), xv[k], m_busy[k]);
        chk($sformatf("model%0d.x_out", k), xo[k], m_busy[k] ? m_bit(k) : cfg_idle(k));
        chk($sformatf("model%0d.done", k), dn[k], m_done(k));
        chk($sformatf("model%0d.state", k), st[k],
            m_busy[k] ? 2'd1 : (m_gap[k] > 0 ? 2'd2 : 2'd0));
      end
    end
  end

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  // Accept one word, then check its 8 bits (seq[7] is the first bit out); an optional
  // in_valid pulse with 8'h11 is raised on bit pulse_at.
  task automatic send_word(input int k, input logic [7:0] data, input logic [7:0] seq,
                           input int pulse_at, input string tag);
    iv[k] = 1'b1;
    id[k] = data;
    to_neg();
    chk({tag, ".ready_before"}, rdy[k], 1);
    to_next();
    for (int i = 0; i < 8; i++) begin
      iv[k] = (i == pulse_at);
      id[k] = (i == pulse_at) ? 8'h11 : data;
      to_neg();
      chk($sformatf("%s.bit%0d", tag, i), xo[k], seq[7 - i]);
      chk($sformatf("%s.done%0d", tag, i), dn[k], (i == 7));
      to_next();
    end
    iv[k] = 1'b0;
  endtask

  task automatic gap_check(input int k, input string tag);
    to_neg();
    chk({tag, ".gap_valid"}, xv[k], 0);
    chk({tag, ".gap_xout"}, xo[k], cfg_idle(k));
    chk({tag, ".gap_ready"}, rdy[k], 0);
    to_next();
    to_neg();
    chk({tag, ".after_gap_ready"}, rdy[k], 1);
    to_next();
  endtask

  logic [10:0] stall_seq;
  logic [7:0]  rst_seq;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b1;
      iv[k]    = 1'b0;
      en_s[k]  = 1'b1;
      id[k]    = 8'h00;
    end
    to_next();
    to_neg();
    chk("reset.ready_low_in_rst", rdy[0], 0);
    to_next();
    for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
    to_neg();
    chk("reset.state", st[0], 0);
    chk("reset.x_valid", xv[0], 0);
    chk("reset.done", dn[0], 0);
    chk("reset.idle_bit_hi", xo[1], 1);
    chk("reset.ready", rdy[0], 1);
    to_next();

    send_word(0, 8'hA5, 8'b10100101, -1, "msb_a5");
    gap_check(0, "msb_a5");

    send_word(1, 8'hA5, 8'b10100101, -1, "lsb_a5");
    gap_check(1, "lsb_a5");
    send_word(1, 8'h0F, 8'b11110000, -1, "lsb_0f");
    gap_check(1, "lsb_0f");

    // Back-to-back words with no gap.
    iv[2] = 1'b1;
    id[2] = 8'hFF;
    to_neg();
    to_next();
    id[2] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      iv[2] = (i <= 7);
      to_neg();
      chk($sformatf("gap0.valid%0d", i), xv[2], 1);
      chk($sformatf("gap0.bit%0d", i), xo[2], (i < 8));
      chk($sformatf("gap0.done%0d", i), dn[2], (i == 7 || i == 15));
      to_next();
    end
    iv[2] = 1'b0;
    to_neg();
    chk("gap0.end_valid", xv[2], 0);
    chk("gap0.end_ready", rdy[2], 1);
    to_next();

    // Stall for 3 cycles on bit index 3.
    stall_seq = 11'b10100000101;
    iv[0] = 1'b1;
    id[0] = 8'hA5;
    to_neg();
    to_next();
    iv[0] = 1'b0;
    for (int c = 0; c < 11; c++) begin
      en_s[0] = !(c >= 3 && c <= 5);
      to_neg();
      chk($sformatf("stall.bit%0d", c), xo[0], stall_seq[10 - c]);
      chk($sformatf("stall.done%0d", c), dn[0], (c == 10));
      to_next();
    end
    en_s[0] = 1'b1;
    gap_check(0, "stall");

    // Reset in the middle of a word.
    rst_seq = 8'hC3;
    iv[0] = 1'b1;
    id[0] = 8'hC3;
    to_neg();
    to_next();
    iv[0] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      rst_s[0] = (c == 5);
      to_neg();
      chk($sformatf("midrst.bit%0d", c), xo[0], rst_seq[7 - c]);
      chk($sformatf("midrst.done%0d", c), dn[0], 0);
      if (c == 5) chk("midrst.ready_in_rst", rdy[0], 0);
      to_next();
    end
    rst_s[0] = 1'b0;
    to_neg();
    chk("midrst.after_valid", xv[0], 0);
    chk("midrst.after_xout", xo[0], 0);
    chk("midrst.after_done", dn[0], 0);
    chk("midrst.after_state", st[0], 0);
    chk("midrst.after_ready", rdy[0], 1);
    to_next();
    send_word(0, 8'h3C, 8'b00111100, -1, "fresh_3c");
    gap_check(0, "fresh_3c");

    // Word offered while busy is dropped.
    send_word(0, 8'hA5, 8'b10100101, 2, "ignore");
    gap_check(0, "ignore");
    for (int i = 0; i < 4; i++) begin
      to_neg();
      chk($sformatf("ignore.idle%0d", i), xv[0], 0);
      to_next();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_bit_src.md
SERIAL_BIT_SRC -- requirements
Module: serial_bit_src

Interface
REQ-001 Parameter WIDTH, default 8: bits per word, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 shifts out MSB first, 0 shifts out LSB first.
REQ-003 Parameter GAP, default 1: idle cycles inserted after each word, legal range 0..15.
REQ-004 Parameter IDLE_BIT, default 0: value driven on x_out when no word bit is presented.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-007 in_valid  input  1  in_data holds a word to send.
REQ-008 in_data  input  WIDTH  parallel word.
REQ-009 in_ready  output  1  block can accept a word this cycle.
REQ-010 en  input  1  advance enable; 0 stalls the stream.
REQ-011 x_out  output  1  serial bit, wired to the downstream sequence detector x_in.
REQ-012 x_valid  output  1  x_out carries a word bit.
REQ-013 done  output  1  one-cycle pulse on the final bit of a word.
REQ-014 state  output  2  FSM state, for debug.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE=2'b00, SHIFT=2'b01, GAP=2'b10; 2'b11 SHALL return to IDLE on the next edge.
REQ-016 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_data is captured into the shift register and bit counter cleared.
REQ-017 in_ready SHALL be 1 in IDLE, and also in SHIFT during the final bit with en=1 when GAP=0; it SHALL be 0 otherwise.
REQ-018 in_ready SHALL be 0 in any cycle where rst=1.
REQ-019 Latency: the first bit SHALL appear on x_out with x_valid=1 in the cycle after acceptance.
REQ-020 Each bit SHALL be held on x_out while en=0, and advance to the next bit on an edge with en=1.
REQ-021 en SHALL NOT block acceptance in IDLE.
REQ-022 done SHALL be 1 exactly when in SHIFT, the bit counter equals WIDTH-1, and en=1.
REQ-023 From the final bit with en=1 the FSM SHALL go to GAP if GAP>0.
REQ-024 From the final bit with en=1 and GAP=0, the FSM SHALL go to SHIFT with the new word if a word is accepted that edge, else to IDLE.
REQ-025 In GAP, x_out SHALL be IDLE_BIT and x_valid=0; GAP SHALL last exactly GAP cycles, independent of en, then go to IDLE.
REQ-026 In IDLE, x_out SHALL be IDLE_BIT and x_valid=0.
REQ-027 in_valid asserted while in_ready=0 SHALL be ignored; no word is queued.
REQ-028 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.
REQ-029 The gap counter SHALL be 4 bits wide.

Reset
REQ-030 On an edge with rst=1: state=IDLE, shift register=0, counters=0.
REQ-031 After a reset edge, x_out=IDLE_BIT, x_valid=0 and done=0; in_ready follows REQ-017/REQ-018.
REQ-032 Reset mid-word SHALL abandon the word with no done pulse; the next accepted word starts cleanly.

Structure
REQ-033 Package serial_src_pkg SHALL hold the state encodings (S_IDLE, S_SHIFT, S_GAP) and the gap-counter width constant.
REQ-034 The block SHALL be a single module with no sub-module; the shift register, bit counter and gap counter SHALL be inline registers.

Verification
REQ-035 Test MSB_FIRST=1, WIDTH=8: accept 8'hA5 with en=1 -> x_out 1,0,1,0,0,1,0,1 on cycles 1..8, done on cycle 8, x_valid=0 for 1 GAP cycle, then in_ready=1.
REQ-036 Test MSB_FIRST=0: accept 8'hA5 -> x_out 1,0,1,0,0,1,0,1 reversed, i.e. 1,0,1,0,0,1,0,1 for LSB order; repeat with 8'h0F -> 1,1,1,1,0,0,0,0.
REQ-037 Test GAP=0 with in_valid held high, words 8'hFF then 8'h00 -> 16 contiguous x_valid cycles, done on cycles 8 and 16, no idle bit between words.
REQ-038 Test en=0 for 3 cycles during bit 3 of 8'hA5 -> bit 3 held 4 cycles total, done delayed by 3 cycles, sequence otherwise unchanged.
REQ-039 Test rst=1 at bit 5 of 8'hC3 -> next cycle x_valid=0 and x_out=IDLE_BIT with no done pulse; a fresh 8'h3C sends correctly.
REQ-040 Test in_valid pulsed with 8'h11 during SHIFT -> 8'h11 never appears on x_out and the current word is intact.
